// File: rtl/pc_fetch_unit.sv
// Program-counter stage feeding the instruction decoder, plus Enter push-button
// conditioning (synchronise, debounce, single-pulse on press).
module pc_fetch_unit #(
  parameter int                    ADDR_WIDTH      = 10,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = '0,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enter_n,
  input  logic                  pc_write,
  input  logic [1:0]            jump,
  input  logic                  branch,
  input  logic                  bne,
  input  logic                  zero,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic [ADDR_WIDTH-1:0] jr_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic                  enter_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   synced;
  logic                   take_branch;

  assign pc          = pc_q;
  assign pc_plus1    = pc_q + ADDR_WIDTH'(1);
  assign enter_pulse = pulse_q;
  assign synced      = sync_q[SYNC_STAGES-1];
  assign take_branch = (branch & zero) | (bne & ~zero);

  // Register jump beats absolute jump beats conditional branch; jump=11 falls through.
  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      if (jump == 2'b10)
        pc_d = jr_target;
      else if (jump == 2'b01)
        pc_d = jump_target;
      else if (take_branch)
        pc_d = pc_plus1 + branch_offset;
      else
        pc_d = pc_plus1;
    end
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], enter_n};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
      // Only the released->pressed transition (stable 1 -> 0) strobes.
      pulse_d  = stable_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= BOOT_ADDR;
      sync_q   <= '1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomised bench for pc_fetch_unit: PC selection via an expected
// queue, Enter conditioning via pulse counting windows.
module tb_pc_fetch_unit;

  localparam int AW = 10;

  logic          clock;
  logic          reset;
  logic          enter_n;
  logic          pc_write;
  logic [1:0]    jump;
  logic          branch;
  logic          bne;
  logic          zero;
  logic [AW-1:0] branch_offset;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] jr_target;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus1;
  logic          enter_pulse;

  logic [AW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  pc_fetch_unit #(
    .ADDR_WIDTH      (AW),
    .BOOT_ADDR       (10'd0),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enter_n       (enter_n),
    .pc_write      (pc_write),
    .jump          (jump),
    .branch        (branch),
    .bne           (bne),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .enter_pulse   (enter_pulse)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference next-PC from the selection rules.
  function automatic logic [AW-1:0] model_next(
    input logic [AW-1:0] cur, input logic pw, input logic [1:0] jmp,
    input logic br, input logic bn, input logic z,
    input logic [AW-1:0] off, input logic [AW-1:0] jt, input logic [AW-1:0] jrt);
    logic [AW-1:0] seq;
    seq = cur + AW'(1);
    if (!pw)                          return cur;
    if (jmp == 2'b10)                 return jrt;
    if (jmp == 2'b01)                 return jt;
    if ((br && z) || (bn && !z))      return seq + off;
    return seq;
  endfunction

  // Driver: apply one cycle of decoder controls, queue the expected PC, compare after the edge.
  task automatic pc_step(input string tag, input logic pw, input logic [1:0] jmp,
                         input logic br, input logic bn, input logic z,
                         input logic [AW-1:0] off, input logic [AW-1:0] jt,
                         input logic [AW-1:0] jrt, input logic [AW-1:0] exp);
    pc_write      = pw;
    jump          = jmp;
    branch        = br;
    bne           = bn;
    zero          = z;
    branch_offset = off;
    jump_target   = jt;
    jr_target     = jrt;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    check(tag, pc, exp_q.pop_front());
    pc_write = 1'b0;
  endtask

  // Counts pulse cycles over n edges; first = edge index of the first pulse (0 if none).
  task automatic pulse_window(input int n, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      if (enter_pulse === 1'b1) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
  endtask

  initial begin
    int cnt;
    int first;
    logic [AW-1:0] cur;
    logic          r_pw;
    logic [1:0]    r_jmp;
    logic          r_br, r_bn, r_z;
    logic [AW-1:0] r_off, r_jt, r_jrt, r_exp;

    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    enter_n       = 1'b1;
    pc_write      = 1'b0;
    jump          = 2'b00;
    branch        = 1'b0;
    bne           = 1'b0;
    zero          = 1'b0;
    branch_offset = '0;
    jump_target   = '0;
    jr_target     = '0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_pc", pc, 10'd0);
    check("reset_pc_plus1", pc_plus1, 10'd1);
    check("reset_pulse", enter_pulse, 1'b0);
    reset = 1'b1;

    // Sequential and hold
    pc_step("jump_to_5", 1, 2'b01, 0, 0, 0, 10'd0, 10'd5, 10'd0, 10'd5);
    pc_step("seq_5_6", 1, 2'b00, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd6);
    for (int i = 0; i < 3; i++)
      pc_step("hold_6", 0, 2'b01, 1, 0, 1, 10'd7, 10'd99, 10'd77, 10'd6);
    check("pc_plus1_at_6", pc_plus1, 10'd7);

    // Branches
    pc_step("jump_to_10", 1, 2'b01, 0, 0, 0, 10'd0, 10'd10, 10'd0, 10'd10);
    pc_step("beq_taken_neg", 1, 2'b00, 1, 0, 1, 10'h3FD, 10'd0, 10'd0, 10'd8);
    pc_step("jump_to_10b", 1, 2'b01, 0, 0, 0, 10'd0, 10'd10, 10'd0, 10'd10);
    pc_step("bne_not_taken", 1, 2'b00, 0, 1, 1, 10'h3FD, 10'd0, 10'd0, 10'd11);
    pc_step("bne_taken", 1, 2'b00, 0, 1, 0, 10'd5, 10'd0, 10'd0, 10'd17);
    pc_step("beq_not_taken", 1, 2'b00, 1, 0, 0, 10'd5, 10'd0, 10'd0, 10'd18);
    pc_step("jump11_seq", 1, 2'b11, 0, 0, 0, 10'd0, 10'd300, 10'd200, 10'd19);

    // Wrap
    pc_step("jump_to_1023", 1, 2'b01, 0, 0, 0, 10'd0, 10'd1023, 10'd0, 10'd1023);
    check("pc_plus1_wrap", pc_plus1, 10'd0);
    pc_step("seq_wrap", 1, 2'b00, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
    pc_step("branch_wrap_back", 1, 2'b00, 1, 0, 1, 10'h3FE, 10'd0, 10'd0, 10'd1023);

    // Jump priority
    pc_step("jr_priority", 1, 2'b10, 1, 0, 1, 10'd4, 10'd300, 10'd200, 10'd200);
    pc_step("j_priority", 1, 2'b01, 1, 0, 1, 10'd4, 10'd300, 10'd200, 10'd300);

    // Randomised PC steps against the reference
    cur = 10'd300;
    for (int i = 0; i < 40; i++) begin
      r_pw  = 1'($urandom_range(0, 3) != 0);
      r_jmp = 2'($urandom_range(0, 3));
      r_br  = 1'($urandom_range(0, 1));
      r_bn  = 1'($urandom_range(0, 1));
      r_z   = 1'($urandom_range(0, 1));
      r_off = AW'($urandom_range(0, 1023));
      r_jt  = AW'($urandom_range(0, 1023));
      r_jrt = AW'($urandom_range(0, 1023));
      r_exp = model_next(cur, r_pw, r_jmp, r_br, r_bn, r_z, r_off, r_jt, r_jrt);
      pc_step("rand_pc", r_pw, r_jmp, r_br, r_bn, r_z, r_off, r_jt, r_jrt, r_exp);
      cur = r_exp;
    end

    // Asynchronous reset mid-cycle
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_pc", pc, 10'd0);
    check("async_reset_pc_plus1", pc_plus1, 10'd1);
    check("async_reset_pulse", enter_pulse, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Press and hold: one pulse after edge 6
    @(posedge clock);
    #1;
    enter_n = 1'b0;
    pulse_window(20, cnt, first);
    check("hold_pulse_count", cnt, 1);
    check("hold_pulse_edge", first, 6);

    // Release after hold: no pulse
    enter_n = 1'b1;
    pulse_window(20, cnt, first);
    check("release_pulse_count", cnt, 0);

    // 3-cycle glitch: no pulse
    enter_n = 1'b0;
    pulse_window(3, cnt, first);
    check("glitch_low_count", cnt, 0);
    enter_n = 1'b1;
    pulse_window(15, cnt, first);
    check("glitch_after_count", cnt, 0);

    // Second genuine press after the glitch still works
    enter_n = 1'b0;
    pulse_window(12, cnt, first);
    check("press2_pulse_count", cnt, 1);
    check("press2_pulse_edge", first, 6);
    enter_n = 1'b1;
    pulse_window(15, cnt, first);
    check("release2_pulse_count", cnt, 0);

    // Reset mid-debounce restarts the full latency
    enter_n = 1'b0;
    pulse_window(4, cnt, first);
    check("pre_reset_count", cnt, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_debounce_reset_pulse", enter_pulse, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    pulse_window(20, cnt, first);
    check("restart_pulse_count", cnt, 1);
    check("restart_pulse_edge", first, 6);
    enter_n = 1'b1;
    pulse_window(10, cnt, first);
    check("final_release_count", cnt, 0);

    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the instruction decoder.
- Holds the PC and selects the next PC from sequential, branch, bne, jump and jr sources, using the decoder's Jump/Branch/BNE/PCwrite signals.
- Conditions the raw Enter push-button (synchronise, debounce, single-pulse) into a one-cycle strobe that drives the decoder's Enter input, so each press advances exactly one I/O or endProc instruction.

Parameters:
ADDR_WIDTH, 10, PC / instruction-address width in words
BOOT_ADDR, 0, PC value loaded on reset
SYNC_STAGES, 2, flip-flops in enter_n synchroniser (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button change (>=1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enter_n  input  1  raw Enter push-button, asynchronous, low = pressed
pc_write  input  1  PC update enable from decoder (PCwrite)
jump  input  2  00 sequential/branch, 01 absolute jump (j/jal), 10 register jump (jr), 11 treated as 00
branch  input  1  beq indication
bne  input  1  bne indication
zero  input  1  ALU zero flag of current instruction
branch_offset  input  ADDR_WIDTH  signed word offset relative to pc+1
jump_target  input  ADDR_WIDTH  absolute target for jump=01
jr_target  input  ADDR_WIDTH  register value for jump=10
pc  output  ADDR_WIDTH  current PC, registered
pc_plus1  output  ADDR_WIDTH  pc+1 modulo 2^ADDR_WIDTH, combinational (jal link)
enter_pulse  output  1  one-cycle strobe per debounced press, registered

Behaviour:
- Reset (reset=0, async, overrides everything):
  - pc=BOOT_ADDR, enter_pulse=0.
  - All synchroniser stages=1, debounced state=1 (released), debounce counter=0.
  - Any in-progress debounce count or pending pulse is discarded.
- Next-PC selection (priority order):
  1. jump=10 -> jr_target
  2. jump=01 -> jump_target
  3. (branch & zero) | (bne & ~zero) -> pc_plus1 + branch_offset
  4. otherwise -> pc_plus1
- PC arithmetic:
  - All PC arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
  - branch_offset is two's complement; the sum is truncated.
- PC update:
  - pc loads next-PC on a rising edge only when pc_write=1; otherwise it holds.
  - Latency is one cycle: the pc seen by the decoder changes the cycle after pc_write is sampled high.
- Enter synchroniser: enter_n passes through SYNC_STAGES flip-flops; only the last stage feeds the debouncer.
- Debouncer:
  - Keeps a stable state S (reset 1) and a counter C.
  - When synced input equals S, C<=0.
  - When it differs and C<DEBOUNCE_CYCLES-1, C<=C+1.
  - When it differs and C=DEBOUNCE_CYCLES-1, then S<=synced input and C<=0.
  - Any glitch back to S before the count completes clears C.
- Pulse generation:
  - enter_pulse<=1 on the edge where S changes 1->0 (press); otherwise enter_pulse<=0.
  - Release (0->1) produces no pulse.
  - A held button produces exactly one pulse.
- Press latency: enter_pulse is high in the cycle after edge number SYNC_STAGES+DEBOUNCE_CYCLES, counted from the first edge that samples enter_n=0.
- enter_pulse is independent of pc_write and never lasts more than 1 cycle.
- Simultaneous pc_write and enter_pulse carry no special interaction: the decoder combines them.

Test Plan:
- Reset: BOOT_ADDR=0, drive enter_n=1, pulse reset low mid-cycle -> pc=0 and enter_pulse=0 immediately, without waiting for a clock edge; pc_plus1=1.
- Sequential and hold: pc=5, pc_write=1, jump=00, branch=0 -> pc=6 next cycle. Then pc_write=0 for 3 cycles -> pc stays 6.
- Branch and wrap:
  - pc=10, branch=1, zero=1, branch_offset=-3 -> pc=8.
  - bne=1, zero=1 -> pc=11.
  - pc=1023, jump=00 -> pc=0.
- Jump priority: jump=10, jr_target=200, jump_target=300, branch=1, zero=1 -> pc=200. jump=01 -> pc=300.
- Debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
  - Hold enter_n=0 -> enter_pulse high for exactly 1 cycle, after edge 6.
  - A 3-cycle low glitch -> no pulse.
  - Release after holding -> no pulse.
- Reset mid-debounce: enter_n=0 for 4 cycles, assert reset, release with enter_n=0 still held -> full 6-edge latency restarts; exactly one pulse follows.
